// File: rtl/iir_fixed_pkg.sv
// Shared fixed-point formats, FSM encoding and width helpers for the IIR
// output capture block.
package iir_fixed_pkg;

  // Filter input sample format (the format captured samples return to)
  localparam int WI_IN_DEF  = 3;
  localparam int WF_IN_DEF  = 7;
  // Filter output format
  localparam int WI_OUT_DEF = 8;
  localparam int WF_OUT_DEF = 18;
  // Captured sample format
  localparam int WI_Q_DEF   = WI_IN_DEF;
  localparam int WF_Q_DEF   = WF_IN_DEF;
  // Capture FIFO geometry
  localparam int DEPTH_DEF  = 16;
  localparam int AW_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  // Width of the rounded value once the discarded fraction bits are dropped.
  // The rounding add is one bit wider than the input so it never wraps.
  function automatic int quant_shr_width(input int wi_out, input int wf_out,
                                         input int wf_q);
    return (wi_out + wf_out + 1) - (wf_out - wf_q);
  endfunction

endpackage

// File: rtl/iir_output_capture_if.sv
// Sample stream in, capture FIFO read port out.
interface iir_output_capture_if #(
  parameter int W_IN = 26,
  parameter int W_Q  = 10
);
  logic                   in_valid;
  logic signed [W_IN-1:0] Filt_Out;
  logic                   overFlow;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [W_Q-1:0]         rd_data;
  logic                   rd_sat;

  modport master (
    output in_valid, Filt_Out, overFlow, rd_ready,
    input  rd_valid, rd_data, rd_sat
  );

  modport slave (
    input  in_valid, Filt_Out, overFlow, rd_ready,
    output rd_valid, rd_data, rd_sat
  );
endinterface

// File: rtl/iir_capture_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; head data reads as zero while empty.
module iir_capture_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rd_data   = empty ? {DW{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update: flush empties the FIFO, otherwise advance on push/pop
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since reads are gated by empty
  always_ff @(posedge CLK) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/iir_output_capture.sv
// Re-quantises the IIR filter output to the input sample format (round half
// up, saturate), and captures a programmed number of samples into a FIFO.
module iir_output_capture
  import iir_fixed_pkg::*;
#(
  parameter int WI_OUT = WI_OUT_DEF,
  parameter int WF_OUT = WF_OUT_DEF,
  parameter int WI_Q   = WI_Q_DEF,
  parameter int WF_Q   = WF_Q_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                 CLK,
  input  logic                 Reset,
  iir_output_capture_if.slave  s,
  input  logic                 start,
  input  logic [7:0]           capture_len,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           sat_count,
  output logic [7:0]           drop_count
);

  localparam int W_IN  = WI_OUT + WF_OUT;
  localparam int W_Q   = WI_Q + WF_Q;
  localparam int SH    = WF_OUT - WF_Q;
  localparam int W_SUM = W_IN + 1;
  localparam int W_SHR = quant_shr_width(WI_OUT, WF_OUT, WF_Q);

  localparam logic signed [W_SUM-1:0] RND   = {{(W_SUM-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [W_SHR-1:0] Q_MAX = {{(W_SHR-W_Q+1){1'b0}}, {(W_Q-1){1'b1}}};
  localparam logic signed [W_SHR-1:0] Q_MIN = {{(W_SHR-W_Q+1){1'b1}}, {(W_Q-1){1'b0}}};

  cap_state_e              state_r;
  logic                    busy_r;
  logic                    done_r;
  logic [7:0]              len_r;
  logic [7:0]              cnt_r;
  logic [7:0]              sat_cnt_r;
  logic [7:0]              drop_cnt_r;
  logic                    pipe_vld_r;
  logic [W_Q-1:0]          pipe_data_r;
  logic                    pipe_sat_r;

  logic signed [W_SUM-1:0] sum_s;
  logic signed [W_SHR-1:0] rounded_s;
  logic [W_Q-1:0]          q_data_s;
  logic                    q_sat_s;
  logic                    accept_s;
  logic                    flush_s;
  logic                    pop_fire_s;
  logic                    drop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [W_Q:0]            fifo_rd_s;

  assign sum_s      = {s.Filt_Out[W_IN-1], s.Filt_Out} + RND;
  assign rounded_s  = sum_s[W_SUM-1:SH];
  assign accept_s   = s.in_valid && (state_r == ST_CAPTURE) && (cnt_r < len_r);
  assign flush_s    = start && (state_r != ST_CAPTURE);
  assign pop_fire_s = s.rd_ready && !fifo_empty_s;
  assign drop_s     = pipe_vld_r && fifo_full_s && !pop_fire_s;

  // Clamp the rounded value to the capture range; overFlow also marks sat
  always_comb begin
    q_data_s = rounded_s[W_Q-1:0];
    q_sat_s  = s.overFlow;
    if (rounded_s > Q_MAX) begin
      q_data_s = Q_MAX[W_Q-1:0];
      q_sat_s  = 1'b1;
    end else if (rounded_s < Q_MIN) begin
      q_data_s = Q_MIN[W_Q-1:0];
      q_sat_s  = 1'b1;
    end else begin
      q_data_s = rounded_s[W_Q-1:0];
    end
  end

  // Quantise pipeline register, cleared when a new capture starts
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pipe_vld_r  <= 1'b0;
      pipe_data_r <= {W_Q{1'b0}};
      pipe_sat_r  <= 1'b0;
    end else if (flush_s) begin
      pipe_vld_r  <= 1'b0;
      pipe_data_r <= {W_Q{1'b0}};
      pipe_sat_r  <= 1'b0;
    end else begin
      pipe_vld_r <= accept_s;
      if (accept_s) begin
        pipe_data_r <= q_data_s;
        pipe_sat_r  <= q_sat_s;
      end
    end
  end

  // Capture FSM with sample, saturation and drop counters
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      len_r      <= 8'd0;
      cnt_r      <= 8'd0;
      sat_cnt_r  <= 8'd0;
      drop_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= ST_CAPTURE;
            busy_r     <= 1'b1;
            len_r      <= capture_len;
            cnt_r      <= 8'd0;
            sat_cnt_r  <= 8'd0;
            drop_cnt_r <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (accept_s) cnt_r <= cnt_r + 8'd1;
          if (pipe_vld_r && pipe_sat_r && (sat_cnt_r != 8'd255))
            sat_cnt_r <= sat_cnt_r + 8'd1;
          if (drop_s && (drop_cnt_r != 8'd255))
            drop_cnt_r <= drop_cnt_r + 8'd1;
          // The last sample is written by the pipeline on this same edge
          if (cnt_r == len_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  iir_capture_fifo #(
    .DW    (W_Q + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLK     (CLK),
    .Reset   (Reset),
    .flush   (flush_s),
    .push    (pipe_vld_r),
    .pop     (s.rd_ready),
    .wr_data ({pipe_sat_r, pipe_data_r}),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign s.rd_valid = !fifo_empty_s;
  assign s.rd_data  = fifo_rd_s[W_Q-1:0];
  assign s.rd_sat   = fifo_rd_s[W_Q];
  assign busy       = busy_r;
  assign done       = done_r;
  assign sat_count  = sat_cnt_r;
  assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_iir_output_capture.sv
// Scoreboard bench for iir_output_capture: expected {sat,data} values are
// queued as samples are driven and compared as the reader pops them.
module tb_iir_output_capture;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] capture_len = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] sat_count;
  logic [7:0] drop_count;

  iir_output_capture_if #(.W_IN(26), .W_Q(10)) bus ();

  iir_output_capture dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .s           (bus),
    .start       (start),
    .capture_len (capture_len),
    .busy        (busy),
    .done        (done),
    .sat_count   (sat_count),
    .drop_count  (drop_count)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  logic [10:0] sb[$];

  always @(posedge CLK) if (done === 1'b1) done_seen <= done_seen + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent reference: round half up to Q3.7, clamp, flag sat
  function automatic logic [10:0] model_q(input logic [25:0] v, input logic ovf);
    longint x;
    longint r;
    logic [63:0] rb;
    logic sat;
    x   = longint'($signed(v));
    r   = (x + 64'sd1024) >>> 11;
    sat = ovf;
    if (r > 64'sd511) begin r = 64'sd511; sat = 1'b1; end
    if (r < -64'sd512) begin r = -64'sd512; sat = 1'b1; end
    rb = r;
    return {sat, rb[9:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1;
    capture_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [25:0] v, input logic ovf);
    bus.in_valid = 1'b1;
    bus.Filt_Out = v;
    bus.overFlow = ovf;
    tick();
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.Filt_Out = 26'd0;
    bus.overFlow = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  function automatic logic [25:0] rand_sample(input int i);
    logic [25:0] v;
    v = 26'($urandom());
    if (i % 2 == 1) v = {{8{v[17]}}, v[17:0]};
    return v;
  endfunction

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy, done, bus.rd_valid, bus.rd_sat} !== 4'b0000 || bus.rd_data !== 10'd0 ||
        sat_count !== 8'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b rd_valid=%b rd_sat=%b rd_data=%h sat=%0d drop=%0d, want all 0",
               busy, done, bus.rd_valid, bus.rd_sat, bus.rd_data, sat_count, drop_count);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_rounding();
    logic [25:0] vals [6];
    logic [10:0] exps [6];
    logic [10:0] e;
    int base;
    vals = '{26'h0040000, 26'h0000400, 26'h00003FF, 26'h3FFFC00, 26'h0140000, 26'h3EC0000};
    exps = '{11'h080, 11'h001, 11'h000, 11'h000, 11'h5FF, 11'h600};
    base = done_seen;
    do_start(8'd6);
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exps[i]);
      push(vals[i], 1'b0);
    end
    idle_in();
    tick(); tick(); tick();
    vectors++;
    if (sat_count !== 8'd2 || busy !== 1'b0 || done_seen - base != 1) begin
      miscompares++;
      $display("FAIL rounding_status: sat=%0d busy=%b done_pulses=%0d, want 2 0 1",
               sat_count, busy, done_seen - base);
    end
    for (int i = 0; i < 6; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      vectors++;
      if (bus.rd_valid !== 1'b1 || {bus.rd_sat, bus.rd_data} !== e) begin
        miscompares++;
        $display("FAIL rounding_pop[%0d]: valid=%b sat/data=%h, want valid=1 sat/data=%h",
                 i, bus.rd_valid, {bus.rd_sat, bus.rd_data}, e);
      end
      pop_one();
    end
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rounding_empty: rd_valid=%b, want 0", bus.rd_valid);
    end
  endtask

  task automatic test_overflow_flag();
    do_start(8'd1);
    push(26'd0, 1'b1);
    idle_in();
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: rd_valid=%b one edge after accept, want 0", bus.rd_valid);
    end
    tick();
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 10'h000 || bus.rd_sat !== 1'b1 || sat_count !== 8'd1) begin
      miscompares++;
      $display("FAIL overflow_flag: valid=%b data=%h sat=%b sat_count=%0d, want 1 000 1 1",
               bus.rd_valid, bus.rd_data, bus.rd_sat, sat_count);
    end
    pop_one();
  endtask

  task automatic test_fill_overflow();
    logic [25:0] v;
    logic [10:0] m;
    logic [10:0] e;
    int sat_exp = 0;
    bus.rd_ready = 1'b0;
    do_start(8'd20);
    for (int i = 0; i < 20; i++) begin
      v = rand_sample(i);
      m = model_q(v, 1'b0);
      if (m[10]) sat_exp++;
      if (i < 16) sb.push_back(m);
      push(v, 1'b0);
    end
    idle_in();
    tick(); tick(); tick();
    vectors++;
    if (drop_count !== 8'd4 || sat_count !== 8'(sat_exp) || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_status: drop=%0d sat=%0d rd_valid=%b, want 4 %0d 1",
               drop_count, sat_count, bus.rd_valid, sat_exp);
    end
    for (int i = 0; i < 16; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      vectors++;
      if (bus.rd_valid !== 1'b1 || {bus.rd_sat, bus.rd_data} !== e) begin
        miscompares++;
        $display("FAIL fill_pop[%0d]: valid=%b sat/data=%h, want valid=1 sat/data=%h",
                 i, bus.rd_valid, {bus.rd_sat, bus.rd_data}, e);
      end
      pop_one();
    end
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_empty: rd_valid=%b, want 0", bus.rd_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [25:0] v;
    logic [10:0] e;
    do_start(8'd17);
    for (int i = 0; i < 17; i++) begin
      v = rand_sample(i + 1);
      sb.push_back(model_q(v, 1'b0));
      if (i == 16) begin
        idle_in();
        tick(); tick();
        vectors++;
        if (bus.rd_valid !== 1'b1 || drop_count !== 8'd0) begin
          miscompares++;
          $display("FAIL full_setup: rd_valid=%b drop=%0d, want 1 0", bus.rd_valid, drop_count);
        end
      end
      push(v, 1'b0);
    end
    idle_in();
    // This pop coincides with the write of the 17th sample into a full FIFO
    for (int i = 0; i < 17; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      vectors++;
      if (bus.rd_valid !== 1'b1 || {bus.rd_sat, bus.rd_data} !== e) begin
        miscompares++;
        $display("FAIL full_pop[%0d]: valid=%b sat/data=%h, want valid=1 sat/data=%h",
                 i, bus.rd_valid, {bus.rd_sat, bus.rd_data}, e);
      end
      pop_one();
    end
    vectors++;
    if (bus.rd_valid !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL full_pop_end: rd_valid=%b drop=%0d, want 0 0", bus.rd_valid, drop_count);
    end
  endtask

  task automatic test_len_zero_and_restart();
    logic [25:0] v;
    logic [10:0] m;
    logic [10:0] e;
    int sat_exp;
    do_start(8'd0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_capture: busy=%b done=%b, want 1 0", busy, done);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1 || bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_done: busy=%b done=%b rd_valid=%b, want 0 1 0", busy, done, bus.rd_valid);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_pulse: done=%b, want 0", done);
    end
    // start during CAPTURE must not disturb counters or the latched length
    do_start(8'd4);
    sb.push_back(11'h400); push(26'd0, 1'b1);
    sb.push_back(11'h400); push(26'd0, 1'b1);
    idle_in();
    start = 1'b1; capture_len = 8'd9;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (sat_count !== 8'd2 || busy !== 1'b1 || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_ignored: sat=%0d busy=%b rd_valid=%b, want 2 1 1",
               sat_count, busy, bus.rd_valid);
    end
    sat_exp = 2;
    for (int i = 0; i < 2; i++) begin
      v = rand_sample(i);
      m = model_q(v, 1'b0);
      if (m[10]) sat_exp++;
      sb.push_back(m);
      push(v, 1'b0);
    end
    idle_in();
    tick(); tick(); tick();
    vectors++;
    if (busy !== 1'b0 || sat_count !== 8'(sat_exp)) begin
      miscompares++;
      $display("FAIL restart_len: busy=%b sat=%0d, want 0 %0d", busy, sat_count, sat_exp);
    end
    for (int i = 0; i < 4; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      vectors++;
      if (bus.rd_valid !== 1'b1 || {bus.rd_sat, bus.rd_data} !== e) begin
        miscompares++;
        $display("FAIL restart_pop[%0d]: valid=%b sat/data=%h, want valid=1 sat/data=%h",
                 i, bus.rd_valid, {bus.rd_sat, bus.rd_data}, e);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [25:0] v;
    logic [10:0] m;
    logic [10:0] e;
    int sat_exp = 0;
    int base;
    do_start(8'd8);
    for (int i = 0; i < 3; i++) push(26'd0, 1'b1);
    idle_in();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, bus.rd_valid, bus.rd_sat} !== 4'b0000 || bus.rd_data !== 10'd0 ||
        sat_count !== 8'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b rd_valid=%b rd_sat=%b rd_data=%h sat=%0d drop=%0d, want all 0",
               busy, done, bus.rd_valid, bus.rd_sat, bus.rd_data, sat_count, drop_count);
    end
    sb.delete();
    Reset = 1'b0;
    tick();
    base = done_seen;
    do_start(8'd2);
    vectors++;
    if (busy !== 1'b1 || sat_count !== 8'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL post_reset_start: busy=%b sat=%0d drop=%0d, want 1 0 0", busy, sat_count, drop_count);
    end
    for (int i = 0; i < 2; i++) begin
      v = rand_sample(i);
      m = model_q(v, 1'b0);
      if (m[10]) sat_exp++;
      sb.push_back(m);
      push(v, 1'b0);
    end
    idle_in();
    tick(); tick(); tick();
    vectors++;
    if (sat_count !== 8'(sat_exp) || drop_count !== 8'd0 || done_seen - base != 1) begin
      miscompares++;
      $display("FAIL post_reset_status: sat=%0d drop=%0d done_pulses=%0d, want %0d 0 1",
               sat_count, drop_count, done_seen - base, sat_exp);
    end
    for (int i = 0; i < 2; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      vectors++;
      if (bus.rd_valid !== 1'b1 || {bus.rd_sat, bus.rd_data} !== e) begin
        miscompares++;
        $display("FAIL post_reset_pop[%0d]: valid=%b sat/data=%h, want valid=1 sat/data=%h",
                 i, bus.rd_valid, {bus.rd_sat, bus.rd_data}, e);
      end
      pop_one();
    end
  endtask

  initial begin
    bus.rd_ready = 1'b0;
    idle_in();
    test_reset();
    test_rounding();
    test_overflow_flag();
    test_fill_overflow();
    test_full_pop();
    test_len_zero_and_restart();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
